// File: rtl/vx_commit_arbiter.sv
// rtl/vx_commit_arbiter.sv - round-robin commit/writeback arbiter with packet lock
//
// Merges NUM_REQS commit streams onto one registered writeback port. Sources
// are searched round-robin from the slot after the last grant. Once a
// multi-beat packet starts, the arbiter locks to that source until its eop beat
// has transferred, so packets are never interleaved.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset (0 = in reset)
//   valid_in   - per-source beat valid
//   data_in    - per-source payload, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   eop_in     - per-source last-beat-of-packet flag
//   ready_in   - per-source accept (one-hot or zero)
//   valid_out  - output beat valid
//   data_out   - output payload
//   eop_out    - output last-beat flag
//   sel_out    - source index of the output beat
//   ready_out  - downstream accept

module vx_commit_arbiter #(
   parameter int NUM_REQS   = 5,
   parameter int DATA_WIDTH = 128,
   parameter int SEL_WIDTH  = $clog2(NUM_REQS)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQS-1:0]            valid_in,
   input  logic [NUM_REQS*DATA_WIDTH-1:0] data_in,
   input  logic [NUM_REQS-1:0]            eop_in,
   output logic [NUM_REQS-1:0]            ready_in,
   output logic                           valid_out,
   output logic [DATA_WIDTH-1:0]          data_out,
   output logic                           eop_out,
   output logic [SEL_WIDTH-1:0]           sel_out,
   input  logic                           ready_out
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_e;

   logic                  valid_q,    valid_d;
   logic [DATA_WIDTH-1:0] data_q,     data_d;
   logic                  eop_q,      eop_d;
   logic [SEL_WIDTH-1:0]  sel_q,      sel_d;
   logic [SEL_WIDTH-1:0]  rr_ptr_q,   rr_ptr_d;
   logic [SEL_WIDTH-1:0]  lock_idx_q, lock_idx_d;
   lock_state_e           state_q,    state_d;

   logic                  stall;
   logic                  grant_vld;
   logic [SEL_WIDTH-1:0]  grant_idx;
   logic [DATA_WIDTH-1:0] grant_data;
   logic                  grant_eop;
   logic                  fire;
   int                    cand_idx;

   // The output register can take a new beat whenever it is empty or being
   // unloaded this cycle, which gives back-to-back throughput.
   assign stall = valid_q && !ready_out;

   // Winner selection. While locked, only the locked source is eligible even
   // if it is idle; otherwise search ascending from rr_ptr+1, wrapping on the
   // index value (not a power-of-two wrap).
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand_idx  = 0;
      if (state_q == ST_LOCKED) begin
         grant_idx = lock_idx_q;
         grant_vld = valid_in[lock_idx_q];
      end else begin
         for (int k = 0; k < NUM_REQS; k++) begin
            cand_idx = (int'(rr_ptr_q) + 1 + k) % NUM_REQS;
            if (!grant_vld && valid_in[SEL_WIDTH'(cand_idx)]) begin
               grant_vld = 1'b1;
               grant_idx = SEL_WIDTH'(cand_idx);
            end
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (grant_idx == SEL_WIDTH'(i)) begin
            grant_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign grant_eop = eop_in[grant_idx];

   // Reset gating keeps every ready_in low while the block is held in reset.
   assign fire = grant_vld && !stall && reset;

   always_comb begin
      ready_in = '0;
      if (fire) begin
         ready_in[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      valid_d    = valid_q;
      data_d     = data_q;
      eop_d      = eop_q;
      sel_d      = sel_q;
      rr_ptr_d   = rr_ptr_q;
      lock_idx_d = lock_idx_q;
      state_d    = state_q;
      if (fire) begin
         valid_d  = 1'b1;
         data_d   = grant_data;
         eop_d    = grant_eop;
         sel_d    = grant_idx;
         rr_ptr_d = grant_idx;
         case (state_q)
            ST_IDLE: begin
               if (!grant_eop) begin
                  state_d    = ST_LOCKED;
                  lock_idx_d = grant_idx;
               end
            end
            ST_LOCKED: begin
               // While locked the only possible grant is lock_idx.
               if (grant_eop) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (ready_out) begin
         // Drain: payload fields hold their last values.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q    <= 1'b0;
         data_q     <= '0;
         eop_q      <= 1'b0;
         sel_q      <= '0;
         rr_ptr_q   <= SEL_WIDTH'(NUM_REQS - 1);
         lock_idx_q <= '0;
         state_q    <= ST_IDLE;
      end else begin
         valid_q    <= valid_d;
         data_q     <= data_d;
         eop_q      <= eop_d;
         sel_q      <= sel_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_idx_q <= lock_idx_d;
         state_q    <= state_d;
      end
   end

   assign valid_out = valid_q;
   assign data_out  = data_q;
   assign eop_out   = eop_q;
   assign sel_out   = sel_q;

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// tb/tb_vx_commit_arbiter.sv - scoreboard bench for vx_commit_arbiter

module tb_vx_commit_arbiter;

   localparam int N  = 5;
   localparam int DW = 32;
   localparam int SW = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    valid_in;
   logic [N*DW-1:0] data_in;
   logic [N-1:0]    eop_in;
   logic [N-1:0]    ready_in;
   logic            valid_out;
   logic [DW-1:0]   data_out;
   logic            eop_out;
   logic [SW-1:0]   sel_out;
   logic            ready_out;

   int checks = 0;
   int errors = 0;

   // Per-source pending beats {eop, data}; expected output beats {sel, eop, data}.
   logic [DW:0]    src_q [N][$];
   logic [SW+DW:0] exp_q [$];

   always #5 clk = ~clk;

   vx_commit_arbiter #(
      .NUM_REQS   (N),
      .DATA_WIDTH (DW),
      .SEL_WIDTH  (SW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .eop_in    (eop_in),
      .ready_in  (ready_in),
      .valid_out (valid_out),
      .data_out  (data_out),
      .eop_out   (eop_out),
      .sel_out   (sel_out),
      .ready_out (ready_out)
   );

   function automatic logic [DW-1:0] pl(input int s, input int n);
      return DW'(32'h5A00_0000 | (s << 16) | n);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic src_beat(input int s, input int n, input bit e);
      src_q[s].push_back({e, pl(s, n)});
   endtask

   task automatic exp_beat(input int s, input int n, input bit e);
      exp_q.push_back({SW'(s), e, pl(s, n)});
   endtask

   function automatic bit pending();
      if (exp_q.size() != 0) return 1'b1;
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() != 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic drain(input string name);
      int n = 0;
      while (pending() && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (pending()) begin
         errors++;
         $display("FAIL %s_drain actual_left=%0d required_left=0", name, exp_q.size());
         exp_q.delete();
         for (int i = 0; i < N; i++) src_q[i].delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Source driver: hold each beat until the handshake, then present the next.
   initial begin : driver
      logic [N-1:0] fire;
      logic [DW:0]  b;
      valid_in = '0;
      eop_in   = '0;
      data_in  = '0;
      forever begin
         @(negedge clk);
         fire = valid_in & ready_in;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
         end
         #2;
         for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) begin
               b = src_q[i][0];
               valid_in[i]           = 1'b1;
               eop_in[i]             = b[DW];
               data_in[i*DW +: DW]   = b[DW-1:0];
            end else begin
               valid_in[i]           = 1'b0;
               eop_in[i]             = 1'b0;
               data_in[i*DW +: DW]   = '0;
            end
         end
      end
   end

   // Output monitor: every accepted output beat must match the next expectation.
   initial begin : monitor
      logic [SW+DW:0] e;
      forever begin
         @(negedge clk);
         if (reset && valid_out && ready_out) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL out_unexpected actual sel=%0d data=%h required none", sel_out, data_out);
            end else begin
               e = exp_q.pop_front();
               if ({sel_out, eop_out, data_out} !== e) begin
                  errors++;
                  $display("FAIL out_beat actual sel=%0d eop=%0b data=%h required sel=%0d eop=%0b data=%h",
                           sel_out, eop_out, data_out, e[SW+DW:DW+1], e[DW], e[DW-1:0]);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      reset     = 1'b0;
      ready_out = 1'b1;

      // Fairness: all five single-beat, two rounds starting at source 0.
      for (int r = 0; r < 2; r++) begin
         for (int s = 0; s < N; s++) begin
            src_beat(s, r, 1'b1);
            exp_beat(s, r, 1'b1);
         end
      end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_valid_out", valid_out, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_eop_out", eop_out, 0);
      chk("rst_sel_out", sel_out, 0);
      chk("rst_ready_in", ready_in, 0);
      chk("rst_valid_in_loaded", valid_in, 5'b11111);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rel_ready_in", ready_in, 5'b00001);
      chk("rel_valid_out", valid_out, 0);
      @(negedge clk);
      chk("first_valid_out", valid_out, 1);
      drain("fair");

      // Lock: source 2 three-beat packet with 0 and 4 waiting.
      src_beat(1, 0, 1'b1);
      exp_beat(1, 0, 1'b1);
      drain("pre_lock");
      src_beat(2, 10, 1'b0);
      src_beat(2, 11, 1'b0);
      src_beat(2, 12, 1'b1);
      src_beat(4, 10, 1'b1);
      src_beat(0, 10, 1'b1);
      exp_beat(2, 10, 1'b0);
      exp_beat(2, 11, 1'b0);
      exp_beat(2, 12, 1'b1);
      exp_beat(4, 10, 1'b1);
      exp_beat(0, 10, 1'b1);
      drain("lock");

      // Locked source goes idle mid-packet; source 3 must wait.
      src_beat(1, 20, 1'b0);
      src_beat(3, 20, 1'b1);
      exp_beat(1, 20, 1'b0);
      exp_beat(1, 21, 1'b1);
      exp_beat(3, 20, 1'b1);
      @(negedge clk);
      chk("idle_grant1", ready_in, 5'b00010);
      @(negedge clk);
      chk("idle_ready_a", ready_in, 0);
      chk("idle_valid_a", valid_out, 1);
      @(negedge clk);
      chk("idle_ready_b", ready_in, 0);
      chk("idle_valid_b", valid_out, 0);
      @(negedge clk);
      chk("idle_ready_c", ready_in, 0);
      chk("idle_valid_c", valid_out, 0);
      @(posedge clk);
      #1 src_beat(1, 21, 1'b1);
      drain("idle_lock");

      // Backpressure: four stalled edges, then full rate.
      ready_out = 1'b0;
      for (int r = 0; r < 3; r++) begin
         for (int s = 0; s < N; s++) src_beat(s, 30 + r, 1'b1);
         exp_beat(4, 30 + r, 1'b1);
         for (int s = 0; s < 4; s++) exp_beat(s, 30 + r, 1'b1);
      end
      @(negedge clk);
      chk("bp_first_grant", ready_in, 5'b10000);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("bp_valid", valid_out, 1);
         chk("bp_sel", sel_out, 4);
         chk("bp_data", data_out, pl(4, 30));
         chk("bp_ready_in", ready_in, 0);
      end
      @(posedge clk);
      #1 ready_out = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         chk("bp_rate", valid_out, 1);
      end
      drain("bp");

      // Reset in the middle of a locked 4-beat packet from source 4.
      for (int b = 0; b < 4; b++) src_beat(4, 40 + b, (b == 3));
      src_beat(0, 40, 1'b1);
      exp_beat(4, 40, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_valid", valid_out, 0);
      chk("mid_rst_ready", ready_in, 0);
      chk("mid_rst_sel", sel_out, 0);
      chk("mid_rst_data", data_out, 0);
      chk("mid_rst_eop", eop_out, 0);
      chk("mid_rst_exp_left", exp_q.size(), 0);
      exp_beat(0, 40, 1'b1);
      exp_beat(4, 42, 1'b0);
      exp_beat(4, 43, 1'b1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("post_rst_grant", ready_in, 5'b00001);
      drain("mid_rst");

      // Only source 4 valid: granted every cycle across the 4 -> 0 wrap.
      for (int b = 0; b < 6; b++) begin
         src_beat(4, 50 + b, 1'b1);
         exp_beat(4, 50 + b, 1'b1);
      end
      @(negedge clk);
      chk("solo_grant", ready_in, 5'b10000);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("solo_valid", valid_out, 1);
      end
      drain("solo");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vx_commit_arbiter.md
# vx_commit_arbiter

Round-robin commit/writeback arbiter for the execute stage. It merges up to `NUM_REQS` commit streams (ALU, LD, ST, CSR, FPU, GPU) onto the single writeback/commit port. Multi-beat packets (`eop`-delimited) are never interleaved. The output is registered, full throughput.

## Interface
- `NUM_REQS`, default 5: number of commit sources, ≥2.
- `DATA_WIDTH`, default 128: opaque commit payload width (wid, tmask, PC, rd, wb, data packed by the caller).
- `SEL_WIDTH`, default `$clog2(NUM_REQS)`: source index width.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low (0 = in reset).
- `valid_in`, input, NUM_REQS: per-source beat valid.
- `data_in`, input, NUM_REQS*DATA_WIDTH: per-source payload; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `eop_in`, input, NUM_REQS: per-source last-beat-of-packet flag.
- `ready_in`, output, NUM_REQS: per-source accept; a beat transfers when `valid_in[i] && ready_in[i]`.
- `valid_out`, output, 1: output beat valid.
- `data_out`, output, DATA_WIDTH: output payload.
- `eop_out`, output, 1: output last-beat flag.
- `sel_out`, output, SEL_WIDTH: index of the source of the current output beat.
- `ready_out`, input, 1: downstream accept.

## Operation
- State:
  - output register (`valid_out`/`data_out`/`eop_out`/`sel_out`);
  - `rr_ptr` [SEL_WIDTH], the last granted index;
  - `locked` flag;
  - `lock_idx` [SEL_WIDTH].
- Output register may load when `stall = valid_out && !ready_out` is 0.
- Arbitration, when not locked:
  - Search the valid sources starting at `(rr_ptr+1) mod NUM_REQS`, ascending, wrapping at NUM_REQS-1 → 0.
  - The first valid source wins.
  - Modulo is on index value, not power-of-two wrap. With NUM_REQS=5, the index after 4 is 0.
- Arbitration, when locked: only `lock_idx` is eligible, and other valid sources are ignored even if `lock_idx` is idle.
- Grant: `ready_in[g] = !stall` for the winner g; all other bits are 0. At most one `ready_in` bit is high per cycle. `ready_in` is combinational from `valid_in`, `locked`, `lock_idx`, `rr_ptr`, `valid_out`, `ready_out`.
- On transfer from source g:
  - output register ← {1, data_in[g], eop_in[g], g};
  - `rr_ptr` ← g.
- Lock FSM, 2 states:
  - IDLE → LOCKED on a transfer with `eop_in[g]=0`; `lock_idx` ← g.
  - LOCKED → IDLE on a transfer from `lock_idx` with `eop_in=1`.
  - LOCKED self-loops otherwise.
  - A single-beat packet (eop=1) in IDLE stays in IDLE.
- Output drain: if no transfer occurs and `ready_out` is 1, `valid_out` ← 0. Data, eop and sel hold their last values.
- Reset (asynchronous assert, released synchronously by the upstream relay): clears state immediately mid-packet.
  - `valid_out`=0, `data_out`=0, `eop_out`=0, `sel_out`=0.
  - `rr_ptr`=NUM_REQS-1, so source 0 has first priority.
  - `locked`=0, `lock_idx`=0.
  - All `ready_in` are 0 while in reset.

## Timing
- Latency: 1 cycle from input transfer to `valid_out`.
- Throughput: 1 beat/cycle. Simultaneous unload (`ready_out=1`) and load in the same cycle is required, giving no bubble.
- Backpressure: while `stall`, all `ready_in`=0 and the output register holds stable. Arbitration state does not advance.
- Fairness: with all sources continuously valid and single-beat, each source is granted exactly once per NUM_REQS cycles.
- Upstream sources must hold `valid_in`/`data_in` until accepted. The arbiter does not require `valid_in` to be stable for non-granted sources.
- `valid_in` of a source with no pending beat while locked to it: output drains, no grant, lock persists.

## Test plan
- Reset then all 5 sources valid with single-beat packets, `ready_out`=1 → `sel_out` sequence 0,1,2,3,4,0 on consecutive cycles, first `valid_out` one cycle after reset release.
- Source 2 sends a 3-beat packet (eop on beat 3) while sources 0 and 4 are valid → `sel_out`=2,2,2, then 4, then 0. No interleave.
- Locked source 1 deasserts valid for 2 cycles mid-packet while source 3 is valid → `valid_out` drops, `ready_in[3]` stays 0. When source 1 resumes and sends eop, source 3 is granted next.
- `ready_out`=0 for 4 cycles with all valid → `data_out`/`sel_out` stable, `ready_in`=0. On release, throughput resumes at 1/cycle with no dropped or duplicated beat (scoreboard check of payload order per source).
- Assert `reset`=0 in the middle of a locked 4-beat packet → `valid_out`=0 and lock cleared asynchronously. After release, source 0 wins first even if the locked source is still valid.
- Only source 4 valid continuously, single-beat → granted every cycle, `sel_out`=4, `rr_ptr` wrap from 4 yields search start 0, with no stall cycles.
